// File: rtl/geofence_feeder_if.sv
// Feeder <-> memory / geofence-stage / result-store signal bundle.
// Latency: none, wires only.
// Backpressure: none; strobes (mem_rd, valid, res_we) are fire-and-forget.
interface geofence_feeder_if;
    logic        start;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [19:0] mem_data;
    logic [9:0]  X;
    logic [9:0]  Y;
    logic        gf_hold;
    logic        valid;
    logic        is_inside;
    logic        res_we;
    logic [5:0]  res_addr;
    logic        res_bit;
    logic [6:0]  inside_cnt;
    logic        busy;
    logic        done;
    logic        overrun;

    // Feeder side.
    modport master (
        input  start, mem_data, valid, is_inside,
        output mem_rd, mem_addr, X, Y, gf_hold, res_we, res_addr, res_bit,
               inside_cnt, busy, done, overrun
    );

    // Environment side: memory, geofence stage, result store, control.
    modport slave (
        output start, mem_data, valid, is_inside,
        input  mem_rd, mem_addr, X, Y, gf_hold, res_we, res_addr, res_bit,
               inside_cnt, busy, done, overrun
    );
endinterface

// File: rtl/geofence_feeder.sv
// Streams 7-point frames from point memory to the geofence stage, ping-pong buffered.
// Latency: first object point on X/Y 9 cycles after start; next frame 1 cycle after valid.
// Backpressure: none; an early valid is flagged as overrun and the prefetch still completes.
module geofence_feeder #(
    parameter int FRAMES = 64
) (
    input  logic clk,
    input  logic reset,
    geofence_feeder_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH0, SEND, WAIT, DONE} state_t;

    localparam logic [5:0] LAST_FRM = 6'(FRAMES - 1);

    state_t      state_q, state_d;

    // Read engine and one-cycle-delayed capture pipeline.
    logic        rd_q;
    logic [8:0]  addr_q;
    logic [2:0]  rd_idx;
    logic        rd_buf;
    logic        cap_vld;
    logic [2:0]  cap_idx;
    logic        cap_buf;

    // Ping-pong point buffers; sbuf is the one being streamed.
    logic [19:0] pbuf [2][7];
    logic        sbuf;
    logic [2:0]  snd_cnt;
    logic [5:0]  frm;
    logic        pf_done;
    logic        got_valid;

    logic [9:0]  x_q, y_q;
    logic        hold_q, we_q, wbit_q, busy_q, done_q, ovr_q;
    logic [5:0]  waddr_q;
    logic [6:0]  cnt_q;

    logic        cap_last, more, start_ok, take, go, valid_bad;
    logic        ld_pt, pt_buf;
    logic [2:0]  pt_idx;
    logic [8:0]  pf_base;

    // Run-control qualifiers shared by the FSM and datapath.
    always_comb begin
        cap_last  = cap_vld && (cap_idx == 3'd6);
        more      = (frm != LAST_FRM);
        start_ok  = bus.start && ((state_q == IDLE) || (state_q == DONE));
        take      = bus.valid && (state_q == WAIT) && !got_valid;
        go        = (take || got_valid) && (pf_done || cap_last);
        valid_bad = bus.valid && ((state_q != WAIT) || got_valid || (more && !pf_done));
        pf_base   = (9'(frm) + 9'd1) * 9'd7;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_ok) state_d = FETCH0;
            FETCH0:     if (cap_last) state_d = SEND;
            SEND:       if (snd_cnt == 3'd6) state_d = WAIT;
            WAIT: begin
                if (more) begin
                    if (go) state_d = SEND;
                end else if (take) begin
                    state_d = DONE;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    // Which buffered point, if any, loads onto X/Y at the next edge.
    always_comb begin
        ld_pt  = 1'b0;
        pt_buf = sbuf;
        pt_idx = 3'd0;
        if (state_q == FETCH0 && cap_last) begin
            ld_pt = 1'b1;
        end else if (state_q == SEND && snd_cnt != 3'd6) begin
            ld_pt  = 1'b1;
            pt_idx = snd_cnt + 3'd1;
        end else if (state_q == WAIT && more && go) begin
            ld_pt  = 1'b1;
            pt_buf = ~sbuf;
        end
    end

    // Seven-read bursts: frame 0 on start, next frame on entry to WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= 1'b0;
            addr_q  <= '0;
            rd_idx  <= '0;
            rd_buf  <= 1'b0;
            cap_vld <= 1'b0;
            cap_idx <= '0;
            cap_buf <= 1'b0;
        end else begin
            cap_vld <= rd_q;
            cap_idx <= rd_idx;
            cap_buf <= rd_buf;
            if (start_ok) begin
                rd_q   <= 1'b1;
                addr_q <= '0;
                rd_idx <= '0;
                rd_buf <= 1'b0;
            end else if (state_q == SEND && state_d == WAIT && more) begin
                rd_q   <= 1'b1;
                addr_q <= pf_base;
                rd_idx <= '0;
                rd_buf <= ~sbuf;
            end else if (rd_q) begin
                if (rd_idx == 3'd6) begin
                    rd_q <= 1'b0;
                end else begin
                    rd_idx <= rd_idx + 3'd1;
                    addr_q <= addr_q + 9'd1;
                end
            end
        end
    end

    // Buffer fill; contents need no reset since every entry is written before use.
    always_ff @(posedge clk) begin
        if (cap_vld) pbuf[cap_buf][cap_idx] <= bus.mem_data;
    end

    // Streaming, result write-back, counters and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sbuf      <= 1'b0;
            snd_cnt   <= '0;
            frm       <= '0;
            pf_done   <= 1'b0;
            got_valid <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            hold_q    <= 1'b1;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wbit_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            hold_q <= (state_d == IDLE) || (state_d == FETCH0) || (state_d == DONE);
            busy_q <= (state_d == FETCH0) || (state_d == SEND) || (state_d == WAIT);
            done_q <= (state_d == DONE);

            if (start_ok) begin
                frm     <= '0;
                sbuf    <= 1'b0;
                cnt_q   <= '0;
                waddr_q <= '0;
                ovr_q   <= 1'b0;
            end else if (valid_bad) begin
                ovr_q <= 1'b1;
            end

            if (ld_pt) begin
                x_q <= pbuf[pt_buf][pt_idx][19:10];
                y_q <= pbuf[pt_buf][pt_idx][9:0];
            end

            if (state_q == FETCH0 && cap_last) snd_cnt <= '0;

            if (state_q == SEND) begin
                if (snd_cnt != 3'd6) begin
                    snd_cnt <= snd_cnt + 3'd1;
                end else begin
                    pf_done   <= 1'b0;
                    got_valid <= 1'b0;
                end
            end

            if (state_q == WAIT) begin
                if (cap_last) pf_done <= 1'b1;
                if (take) begin
                    got_valid <= 1'b1;
                    we_q      <= 1'b1;
                    waddr_q   <= frm;
                    wbit_q    <= bus.is_inside;
                    if (bus.is_inside && cnt_q != 7'd64) cnt_q <= cnt_q + 7'd1;
                end
                if (more && go) begin
                    sbuf    <= ~sbuf;
                    frm     <= frm + 6'd1;
                    snd_cnt <= '0;
                end
            end
        end
    end

    assign bus.mem_rd     = rd_q;
    assign bus.mem_addr   = addr_q;
    assign bus.X          = x_q;
    assign bus.Y          = y_q;
    assign bus.gf_hold    = hold_q;
    assign bus.res_we     = we_q;
    assign bus.res_addr   = waddr_q;
    assign bus.res_bit    = wbit_q;
    assign bus.inside_cnt = cnt_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_geofence_feeder.sv
// Randomized bench for geofence_feeder with a schedule-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_geofence_feeder;
    localparam int FR  = 3;
    localparam int MAXT = 400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    geofence_feeder_if gif();

    geofence_feeder #(.FRAMES(FR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (gif.master)
    );

    int checks = 0;
    int failures = 0;

    logic [19:0] mem [0:511];
    int          dly [FR];
    bit          ins [FR];
    int          exp_s [FR];
    int          exp_v [FR];
    int          t_end;

    logic        o_rd   [0:MAXT-1];
    logic [8:0]  o_addr [0:MAXT-1];
    logic [9:0]  o_x    [0:MAXT-1];
    logic [9:0]  o_y    [0:MAXT-1];
    logic        o_hold [0:MAXT-1];
    logic        o_we   [0:MAXT-1];
    logic [5:0]  o_wa   [0:MAXT-1];
    logic        o_wb   [0:MAXT-1];
    logic [6:0]  o_cnt  [0:MAXT-1];
    logic        o_busy [0:MAXT-1];
    logic        o_done [0:MAXT-1];
    logic        o_ovr  [0:MAXT-1];

    // Point memory: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (gif.mem_rd) gif.mem_data <= mem[gif.mem_addr];
    end

    function automatic logic [48:0] obs_vec();
        return {gif.mem_rd, gif.mem_addr, gif.X, gif.Y, gif.gf_hold, gif.res_we,
                gif.res_addr, gif.res_bit, gif.inside_cnt, gif.busy, gif.done, gif.overrun};
    endfunction

    // Reference schedule, t=0 being the start cycle: frame 0 is read in cycles 1..7
    // and streamed from 9; each later frame is read in the 7 cycles after the
    // previous stream, ready 8 cycles later, and streamed at max(valid+1, ready+1).
    function automatic void plan();
        int s;
        s = 9;
        for (int k = 0; k < FR; k++) begin
            exp_s[k] = s;
            exp_v[k] = s + 6 + dly[k];
            s = (exp_v[k] + 1 > s + 15) ? exp_v[k] + 1 : s + 15;
        end
        t_end = exp_v[FR-1] + 3;
    endfunction

    function automatic int m_addr(int t);
        if (t >= 1 && t <= 7) return t - 1;
        for (int k = 0; k < FR - 1; k++)
            if (t >= exp_s[k] + 7 && t <= exp_s[k] + 13) return 7 * (k + 1) + t - exp_s[k] - 7;
        return -1;
    endfunction

    function automatic int m_we(int t);
        for (int k = 0; k < FR; k++) if (t == exp_v[k] + 1) return k;
        return -1;
    endfunction

    function automatic int m_pt(int t);
        int last;
        for (int k = 0; k < FR; k++) begin
            last = (k < FR - 1) ? exp_s[k+1] - 1 : t_end;
            if (t >= exp_s[k] && t <= exp_s[k] + 6) return 7 * k + t - exp_s[k];
            if (t > exp_s[k] + 6 && t <= last) return 7 * k + 6;
        end
        return -1;
    endfunction

    function automatic void load_pattern();
        for (int n = 0; n < 512; n++) mem[n] = {10'(n), 10'h3FF - 10'(n)};
    endfunction

    function automatic void load_random();
        for (int n = 0; n < 512; n++) mem[n] = 20'($urandom);
    endfunction

    // Drives one run per the plan and records every output once per cycle.
    task automatic drive_run(input int start2_t, input int stop_t);
        plan();
        @(negedge clk);
        for (int t = 0; t <= t_end; t++) begin
            o_rd[t] = gif.mem_rd;     o_addr[t] = gif.mem_addr;
            o_x[t] = gif.X;           o_y[t] = gif.Y;
            o_hold[t] = gif.gf_hold;  o_we[t] = gif.res_we;
            o_wa[t] = gif.res_addr;   o_wb[t] = gif.res_bit;
            o_cnt[t] = gif.inside_cnt; o_busy[t] = gif.busy;
            o_done[t] = gif.done;     o_ovr[t] = gif.overrun;
            if (t == stop_t) break;
            gif.start = (t == 0) || (t == start2_t);
            gif.valid = 1'b0;
            gif.is_inside = 1'($urandom);
            for (int k = 0; k < FR; k++)
                if (t == exp_v[k]) begin gif.valid = 1'b1; gif.is_inside = ins[k]; end
            @(negedge clk);
        end
        gif.start = 1'b0;
        gif.valid = 1'b0;
    endtask

    task automatic test_reset();
        gif.start = 1'b0; gif.valid = 1'b0; gif.is_inside = 1'b0; gif.mem_data = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_vec() !== {1'b0, 9'd0, 10'd0, 10'd0, 1'b1, 1'b0, 6'd0, 1'b0, 7'd0, 3'b000}) begin
            failures++; $display("FAIL reset_values got=%h", obs_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch0();
        load_pattern();
        dly = '{40, 40, 40}; ins = '{1, 0, 1};
        drive_run(-1, -1);
        for (int t = 1; t <= 8; t++) begin
            checks++;
            if (o_rd[t] !== (t <= 7) || (t <= 7 && o_addr[t] !== 9'(t - 1))) begin
                failures++; $display("FAIL fetch0_read t=%0d rd=%b addr=%0d exp_addr=%0d", t, o_rd[t], o_addr[t], t - 1);
            end
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (o_x[9+i] !== 10'(i) || o_y[9+i] !== 10'h3FF - 10'(i)) begin
                failures++; $display("FAIL fetch0_stream i=%0d got=%0d,%0d exp=%0d", i, o_x[9+i], o_y[9+i], i);
            end
        end
        checks++;
        if (o_hold[8] !== 1'b1 || o_hold[9] !== 1'b0) begin
            failures++; $display("FAIL gf_hold_fall got=%b%b exp=10", o_hold[8], o_hold[9]);
        end
    endtask

    task automatic test_three_frames();
        load_pattern();
        dly = '{40, 40, 40}; ins = '{1, 0, 1};
        drive_run(-1, -1);
        for (int t = 1; t <= t_end; t++) begin
            int k;
            k = m_we(t);
            checks++;
            if (o_we[t] !== (k >= 0) ||
                (k >= 0 && (o_wa[t] !== 6'(k) || o_wb[t] !== ins[k]))) begin
                failures++; $display("FAIL result_write t=%0d we=%b addr=%0d bit=%b exp_frame=%0d", t, o_we[t], o_wa[t], o_wb[t], k);
            end
        end
        checks++;
        if (o_cnt[t_end] !== 7'd2 || o_done[t_end] !== 1'b1 || o_busy[t_end] !== 1'b0 || o_ovr[t_end] !== 1'b0) begin
            failures++; $display("FAIL run_end cnt=%0d done=%b busy=%b ovr=%b exp=2,1,0,0", o_cnt[t_end], o_done[t_end], o_busy[t_end], o_ovr[t_end]);
        end
    endtask

    task automatic test_overrun();
        load_pattern();
        dly = '{3, 12, 5}; ins = '{bit'($urandom), bit'($urandom), bit'($urandom)};
        drive_run(-1, -1);
        checks++;
        if (o_ovr[exp_v[0]] !== 1'b0 || o_ovr[exp_v[0] + 1] !== 1'b1 || o_ovr[t_end] !== 1'b1) begin
            failures++; $display("FAIL overrun_flag got=%b%b%b exp=011", o_ovr[exp_v[0]], o_ovr[exp_v[0]+1], o_ovr[t_end]);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (o_x[exp_s[1] + i] !== 10'(7 + i)) begin
                failures++; $display("FAIL overrun_frame1 i=%0d got=%0d exp=%0d", i, o_x[exp_s[1]+i], 7 + i);
            end
        end
    endtask

    task automatic test_start_busy();
        load_random();
        dly = '{2, 10, 10}; ins = '{1, 1, 1};
        drive_run(11, -1);
        for (int t = 1; t <= t_end; t++) begin
            int a;
            a = m_addr(t);
            checks++;
            if (o_rd[t] !== (a >= 0) || (a >= 0 && o_addr[t] !== 9'(a))) begin
                failures++; $display("FAIL busy_start_reads t=%0d rd=%b addr=%0d exp=%0d", t, o_rd[t], o_addr[t], a);
            end
        end
        checks++;
        if (o_done[t_end] !== 1'b1 || o_ovr[t_end] !== 1'b1 || o_cnt[t_end] !== 7'd3) begin
            failures++; $display("FAIL busy_start_end done=%b ovr=%b cnt=%0d exp=1,1,3", o_done[t_end], o_ovr[t_end], o_cnt[t_end]);
        end
        dly = '{10, 10, 10}; ins = '{0, 0, 0};
        drive_run(-1, -1);
        checks++;
        if (o_ovr[0] !== 1'b1 || o_done[0] !== 1'b1) begin
            failures++; $display("FAIL sticky_in_done ovr=%b done=%b exp=1,1", o_ovr[0], o_done[0]);
        end
        checks++;
        if (o_ovr[1] !== 1'b0 || o_cnt[1] !== 7'd0 || o_rd[1] !== 1'b1 || o_addr[1] !== 9'd0) begin
            failures++; $display("FAIL restart ovr=%b cnt=%0d rd=%b addr=%0d exp=0,0,1,0", o_ovr[1], o_cnt[1], o_rd[1], o_addr[1]);
        end
    endtask

    task automatic test_reset_mid();
        load_random();
        dly = '{10, 20, 10}; ins = '{1, 1, 1};
        plan();
        drive_run(-1, exp_s[1] + 9);
        reset = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== {1'b0, 9'd0, 10'd0, 10'd0, 1'b1, 1'b0, 6'd0, 1'b0, 7'd0, 3'b000}) begin
            failures++; $display("FAIL async_reset got=%h", obs_vec());
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            gif.valid = (c % 7 == 3);
            gif.is_inside = 1'b1;
            @(negedge clk);
            checks++;
            if (gif.res_we !== 1'b0 || gif.busy !== 1'b0) begin
                failures++; $display("FAIL post_reset c=%0d we=%b busy=%b exp=0,0", c, gif.res_we, gif.busy);
            end
        end
        gif.valid = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int exp_cnt;
            bit exp_ovr;
            load_random();
            exp_cnt = 0; exp_ovr = 0;
            for (int k = 0; k < FR; k++) begin
                dly[k] = $urandom_range(1, 30);
                ins[k] = bit'($urandom);
                exp_cnt += ins[k];
                if (k < FR - 1 && dly[k] <= 8) exp_ovr = 1;
            end
            drive_run(-1, -1);
            for (int t = 1; t <= t_end; t++) begin
                int a, k, p;
                bit h, b, d;
                a = m_addr(t); k = m_we(t); p = m_pt(t);
                h = (t < exp_s[0]) || (t > exp_v[FR-1]);
                b = (t <= exp_v[FR-1]);
                d = (t > exp_v[FR-1]);
                checks++;
                if (o_rd[t] !== (a >= 0) || (a >= 0 && o_addr[t] !== 9'(a))) begin
                    failures++; $display("FAIL rnd_read r=%0d t=%0d rd=%b addr=%0d exp=%0d", r, t, o_rd[t], o_addr[t], a);
                end
                checks++;
                if (o_we[t] !== (k >= 0) || (k >= 0 && (o_wa[t] !== 6'(k) || o_wb[t] !== ins[k]))) begin
                    failures++; $display("FAIL rnd_write r=%0d t=%0d we=%b addr=%0d bit=%b exp_frame=%0d", r, t, o_we[t], o_wa[t], o_wb[t], k);
                end
                if (p >= 0) begin
                    checks++;
                    if ({o_x[t], o_y[t]} !== mem[p]) begin
                        failures++; $display("FAIL rnd_point r=%0d t=%0d got=%h exp=%h", r, t, {o_x[t], o_y[t]}, mem[p]);
                    end
                end
                checks++;
                if (o_hold[t] !== h || o_busy[t] !== b || o_done[t] !== d) begin
                    failures++; $display("FAIL rnd_status r=%0d t=%0d hold/busy/done=%b%b%b exp=%b%b%b", r, t, o_hold[t], o_busy[t], o_done[t], h, b, d);
                end
            end
            checks++;
            if (o_cnt[t_end] !== 7'(exp_cnt) || o_ovr[t_end] !== exp_ovr) begin
                failures++; $display("FAIL rnd_end r=%0d cnt=%0d ovr=%b exp=%0d,%b", r, o_cnt[t_end], o_ovr[t_end], exp_cnt, exp_ovr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch0();
        test_three_frames();
        test_overrun();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/geofence_feeder.md
GEOFENCE_FEEDER -- requirements
Module: geofence_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and reset.
REQ-002 Parameter FRAMES, default 64: number of frames processed per run (1..64).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle run request; honoured only in IDLE or DONE.
REQ-006 mem_rd  output  1  point-memory read strobe.
REQ-007 mem_addr  output  9  point-memory word address.
REQ-008 mem_data  input  20  read data, {X[9:0], Y[9:0]}; valid the cycle after mem_rd.
REQ-009 X, Y  output  10 each  point stream to the geofence stage.
REQ-010 gf_hold  output  1  held-reset request to the geofence stage (ORed into its reset by integration).
REQ-011 valid, is_inside  input  1 each  geofence result strobe and verdict.
REQ-012 res_we, res_addr[5:0], res_bit  output  result write port: one write per frame.
REQ-013 inside_cnt  output  7  count of frames with is_inside=1 in the current run.
REQ-014 busy, done, overrun  output  1 each  run active, run complete, sticky protocol error.

Function
REQ-015 Memory layout: frame k occupies addresses 7k..7k+6; word 7k is the object point, words 7k+1..7k+6 are the six receivers.
REQ-016 The block SHALL contain two 7-entry point buffers (ping-pong): one is streamed while the other is filled.
REQ-017 States: IDLE, FETCH0, SEND, WAIT, DONE.
REQ-018 IDLE: outputs idle, gf_hold=1; start -> FETCH0; inside_cnt, res_addr and overrun cleared on start.
REQ-019 FETCH0: issue 7 consecutive reads for frame 0 (mem_rd=1 for 7 cycles, addr 0..6), capture data one cycle later; after the 7th capture -> SEND.
REQ-020 SEND: drive the 7 buffered points on X,Y on 7 consecutive cycles, object first. gf_hold SHALL be 0 from the first SEND cycle of frame 0 until the run ends. Then -> WAIT. X,Y hold the last point in WAIT.
REQ-021 WAIT: if frames remain, prefetch the next frame into the idle buffer (7 reads, same timing as FETCH0) while waiting for valid.
REQ-022 On valid=1 in WAIT: res_we=1 for that cycle with res_addr=frame index and res_bit=is_inside; inside_cnt increments by is_inside.
REQ-023 After valid, if frames remain: the next cycle is the first SEND cycle of the next frame (object point), buffers swap; otherwise -> DONE.
REQ-024 If valid arrives in WAIT before prefetch completes, overrun SHALL set (sticky until next start); the block completes the prefetch, then sends the frame.
REQ-025 valid outside WAIT is ignored and sets overrun.
REQ-026 DONE: done=1, busy=0, gf_hold=1, mem_rd=0; start -> new run (FETCH0).
REQ-027 busy=1 in FETCH0, SEND, WAIT; start while busy is ignored.
REQ-028 inside_cnt saturates at 64 (never wraps); res_addr counts 0..FRAMES-1.
REQ-029 All outputs are registered; no combinational path from input to output.

Reset
REQ-030 Reset SHALL asynchronously force IDLE and clear mem_rd, mem_addr, X, Y, res_we, res_addr, res_bit, inside_cnt, busy, done, overrun to 0, with gf_hold=1.
REQ-031 Reset mid-run SHALL abort the run with no further res_we; buffer contents are don't-care.

Verification
REQ-032 Reset, start, memory word n = {n, 10'h3FF-n} -> reads addr 0..6, SEND shows X=0..6 on 7 consecutive cycles; gf_hold falls on the cycle X=0.
REQ-033 FRAMES=3, valid pulses 40 cycles after each SEND with is_inside=1,0,1 -> res_we at addr 0,1,2 with bits 1,0,1; inside_cnt=2; done=1.
REQ-034 valid asserted 3 cycles after frame-0 SEND ends -> overrun=1; frame 1 is still sent intact (X=7..13).
REQ-035 Reset asserted during WAIT of frame 1 -> all outputs at reset values within the same cycle; no res_we afterwards.
REQ-036 start pulsed during SEND -> ignored; after DONE, start -> new run with inside_cnt and overrun cleared, reads restart at addr 0.
